rom_rr_arbiter: RTL
===================

// Module: rom_rr_arbiter
// PURPOSE
//   Two-port round-robin arbiter in front of the shared synchronous 32x8 ROM
//   (clk, en, addr, data; data registered one clk after en). Serialises reads
//   from two requesters, drives ROM en/addr, returns data with per-port valid.
//   Sits between the ROM instance and its client blocks; the ROM is unchanged.
// PARAMETERS
//   AW  5   ROM address width
//   DW  8   ROM data width
//   CW  16  grant-counter width (ROM_RR_ARB_STATS_EN only)
// PORTS
//   clk       in   1   clock, all state on rising edge
//   rst       in   1   asynchronous, active-high reset
//   req0      in   1   port 0 read request; held until gnt0
//   addr0     in   AW  port 0 address; held stable while req0 && !gnt0
//   req1      in   1   port 1 read request
//   addr1     in   AW  port 1 address
//   gnt0      out  1   1-cycle pulse: port 0 request accepted
//   gnt1      out  1   1-cycle pulse: port 1 request accepted
//   rvalid0   out  1   1-cycle pulse: rdata holds port 0 result
//   rvalid1   out  1   1-cycle pulse: rdata holds port 1 result
//   rdata     out  DW  read data, held until next rvalid
//   rom_en    out  1   to ROM en
//   rom_addr  out  AW  to ROM addr
//   rom_data  in   DW  from ROM data
//   gcnt0     out  CW  port 0 grant count (ROM_RR_ARB_STATS_EN only)
//   gcnt1     out  CW  port 1 grant count (ROM_RR_ARB_STATS_EN only)
// BEHAVIOUR
//   - Reset (async): state=IDLE, last=1, all outputs 0 (gnt*, rvalid*, rdata,
//     rom_en, rom_addr, gcnt*). Reset mid-transaction aborts it; no rvalid.
//   - FSM IDLE -> ISSUE -> CAPTURE -> IDLE; all outputs registered.
//   - IDLE: if any req, pick winner, latch sel; rom_addr<=addr_sel, rom_en<=1,
//     gnt_sel<=1; go ISSUE. No req: stay, rom_en=0.
//   - ISSUE (1 cycle): gnt cleared, rom_en<=0; ROM registers data; go CAPTURE.
//   - CAPTURE (1 cycle): rdata<=rom_data, rvalid_sel<=1, last<=sel; go IDLE.
//   - Latency: req sampled at edge N -> gnt/rom_en high after N; rvalid high
//     after edge N+2 with rdata valid. Next grant earliest after edge N+3.
//   - Throughput: one read per 3 cycles; one outstanding read max.
//   - Arbitration: only one req -> it wins. Both -> port != last wins
//     (after reset port 0 wins first tie). Strict alternation under
//     continuous dual requests.
//   - Requester drops req on gnt; req still high in IDLE = new read.
//   - Requests arriving in ISSUE/CAPTURE wait; never lost while held.
//   - rom_addr holds last value when idle; rom_en never high 2 cycles running.
//   - gnt0&gnt1 and rvalid0&rvalid1 never both 1.
// CONFIGURATION
//   ROM_RR_ARB_STATS_EN defined: gcnt0/gcnt1 ports present; increment on
//     each gntX pulse, saturate at all-ones, reset to 0.
//   Not defined: gcnt ports and counters absent; behaviour otherwise same.
// TESTING
//   - Reset: rst=1 mid-ISSUE -> all outputs 0 next sample, no rvalid; IDLE.
//   - Single: req0, addr0=10 -> gnt0 after edge 1, rom_en=1 rom_addr=10,
//     rvalid0 after edge 3 with rdata=ROM[10]; rvalid1 stays 0.
//   - Tie after reset: req0 addr 14, req1 addr 17 same cycle -> gnt0 first
//     (rdata=ROM[14]), gnt1 3 cycles later (rdata=ROM[17]).
//   - Fairness: req0/req1 held high 12 reads, addrs 31/26 -> grants alternate
//     0,1,0,1...; 6 each; gcnt0=gcnt1=6 with STATS_EN.
//   - Late arrival: req1 (addr 9) raised during port 0 ISSUE -> served right
//     after port 0 CAPTURE; rdata=ROM[9], no lost or duplicate rvalid.
//   - Saturation (STATS_EN, CW=4): 20 port-0 reads -> gcnt0 stops at 15.

Source files
------------

// File: rtl/rom_rr_arbiter_if.sv
// Client-side bus of the two-port ROM arbiter: per-port request/address in,
// per-port grant and read-valid out, one shared read-data bus.
interface rom_rr_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;

    // requesters drive requests and consume grants/results
    modport master (
        output req0, addr0, req1, addr1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata
    );

    // arbiter consumes requests and returns grants/results
    modport slave (
        input  req0, addr0, req1, addr1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata
    );
endinterface

// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter: two-port round-robin front end for a shared synchronous ROM
// whose data appears one clock after en. One read in flight at a time:
// IDLE (arbitrate, issue en/addr, grant) -> ISSUE (ROM registers data)
// -> CAPTURE (return data with per-port rvalid) -> IDLE.
// Optional build macro ROM_RR_ARB_STATS_EN adds saturating grant counters
// on ports gcnt0/gcnt1.
module rom_rr_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    rom_rr_arbiter_if.slave bus,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data
`ifdef ROM_RR_ARB_STATS_EN
    ,
    output logic [CW-1:0] gcnt0,
    output logic [CW-1:0] gcnt1
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [1:0]    state_r;
    logic          last_r;
    logic          sel_r;
    logic          gnt0_r;
    logic          gnt1_r;
    logic          rvalid0_r;
    logic          rvalid1_r;
    logic [DW-1:0] rdata_r;
    logic          rom_en_r;
    logic [AW-1:0] rom_addr_r;

    logic          any_req_s;
    logic          win_s;
    logic [AW-1:0] win_addr_s;

    // pick the winner: a lone requester wins, a tie goes to the port not served last
    always_comb begin
        any_req_s  = bus.req0 | bus.req1;
        win_s      = 1'b0;
        win_addr_s = bus.addr0;
        if (bus.req0 && bus.req1) begin
            win_s = ~last_r;
        end else if (bus.req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            win_addr_s = bus.addr1;
        end else begin
            win_addr_s = bus.addr0;
        end
    end

    // transaction sequencer; pulse outputs default low each cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            last_r     <= 1'b1;
            sel_r      <= 1'b0;
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            rvalid0_r  <= 1'b0;
            rvalid1_r  <= 1'b0;
            rdata_r    <= {DW{1'b0}};
            rom_en_r   <= 1'b0;
            rom_addr_r <= {AW{1'b0}};
        end else begin
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rom_en_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        sel_r      <= win_s;
                        rom_addr_r <= win_addr_s;
                        rom_en_r   <= 1'b1;
                        gnt0_r     <= ~win_s;
                        gnt1_r     <= win_s;
                        state_r    <= ISSUE;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                ISSUE: begin
                    state_r <= CAPTURE;
                end
                CAPTURE: begin
                    rdata_r   <= rom_data;
                    rvalid0_r <= ~sel_r;
                    rvalid1_r <= sel_r;
                    last_r    <= sel_r;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0    = gnt0_r;
    assign bus.gnt1    = gnt1_r;
    assign bus.rvalid0 = rvalid0_r;
    assign bus.rvalid1 = rvalid1_r;
    assign bus.rdata   = rdata_r;
    assign rom_en      = rom_en_r;
    assign rom_addr    = rom_addr_r;

`ifdef ROM_RR_ARB_STATS_EN
    logic [CW-1:0] gcnt0_r;
    logic [CW-1:0] gcnt1_r;

    // count each visible grant pulse, sticking at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt0_r <= {CW{1'b0}};
            gcnt1_r <= {CW{1'b0}};
        end else begin
            if (gnt0_r && (gcnt0_r != {CW{1'b1}})) begin
                gcnt0_r <= gcnt0_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                gcnt0_r <= gcnt0_r;
            end
            if (gnt1_r && (gcnt1_r != {CW{1'b1}})) begin
                gcnt1_r <= gcnt1_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                gcnt1_r <= gcnt1_r;
            end
        end
    end

    assign gcnt0 = gcnt0_r;
    assign gcnt1 = gcnt1_r;
`endif

endmodule
